// File: rtl/alarm_pkg.sv
// Shared types and constants for the countdown alarm display path.
package alarm_pkg;

  localparam int unsigned TIME_W       = 9;
  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned SEG_W        = 7;
  localparam int unsigned SECS_PER_MIN = 60;
  localparam int unsigned SECS_PER_TEN = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MIN,
    ST_SEC,
    ST_COMMIT
  } conv_state_e;

  // Alarm controller state encodings, shared with the upstream block.
  typedef enum logic [1:0] {
    CTL_SET,
    CTL_RUN,
    CTL_PAUSE,
    CTL_BEEP
  } ctl_state_e;

  // Committed M:SS digits as shown on the display.
  typedef struct packed {
    logic [DIGIT_W-1:0] d2;
    logic [DIGIT_W-1:0] d1;
    logic [DIGIT_W-1:0] d0;
  } digits_t;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns, index 0 in the low slot.
  localparam logic [9:0][SEG_W-1:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/alarm_display_seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; non-decimal codes blank.
module seg7_decode
  import alarm_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (bcd <= 4'd9) begin
      seg_c = SEG_TABLE[bcd];
    end
  end

endmodule

// File: rtl/alarm_display.sv
// Countdown display back end: sequential M:SS conversion, 4-digit scan,
// and zero-time blink/beep, all outputs registered.
module alarm_display
  import alarm_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] time_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       beep
);

  localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  conv_state_e         state_q, state_d;
  logic [TIME_W-1:0]   last_q, last_d;
  logic [TIME_W-1:0]   rem_q, rem_d;
  logic [3:0]          min_q, min_d;
  logic [2:0]          tens_q, tens_d;
  digits_t             digits_q, digits_d;
  logic                zero_q, zero_d;
  logic                valid_q, valid_d;

  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]          dig_q, dig_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;

  logic [SEG_W-1:0]    seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [3:0]          an_q, an_d;
  logic                beep_q, beep_d;

  logic [DIGIT_W-1:0]  cur_bcd_c;
  logic [SEG_W-1:0]    cur_seg_c;

  // Conversion FSM: repeated subtraction of 60 then 10.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    rem_d    = rem_q;
    min_d    = min_q;
    tens_d   = tens_q;
    digits_d = digits_q;
    zero_d   = zero_q;
    valid_d  = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (!valid_q || (time_in != last_q)) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        last_d  = time_in;
        rem_d   = time_in;
        min_d   = 4'd0;
        tens_d  = 3'd0;
        state_d = ST_MIN;
      end
      ST_MIN: begin
        if (rem_q >= TIME_W'(SECS_PER_MIN)) begin
          rem_d = rem_q - TIME_W'(SECS_PER_MIN);
          min_d = min_q + 4'd1;
        end else begin
          state_d = ST_SEC;
        end
      end
      ST_SEC: begin
        if (rem_q >= TIME_W'(SECS_PER_TEN)) begin
          rem_d  = rem_q - TIME_W'(SECS_PER_TEN);
          tens_d = tens_q + 3'd1;
        end else begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        digits_d.d2 = min_q;
        digits_d.d1 = {1'b0, tens_q};
        digits_d.d0 = rem_q[3:0];
        zero_d      = (last_q == '0);
        valid_d     = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Digit scan and blink timers.
  always_comb begin
    scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
    dig_d       = dig_q;
    blink_cnt_d = '0;
    phase_d     = 1'b1;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      dig_d      = dig_q + 2'd1;
    end
    if (zero_q) begin
      phase_d = phase_q;
      if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        phase_d     = !phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  always_comb begin
    case (dig_q)
      2'd0:    cur_bcd_c = digits_q.d0;
      2'd1:    cur_bcd_c = digits_q.d1;
      default: cur_bcd_c = digits_q.d2;
    endcase
  end

  seg7_decode u_seg7_decode (
    .bcd   (cur_bcd_c),
    .seg_c (cur_seg_c)
  );

  // Pin drive: dark until the first commit and during the off blink phase.
  always_comb begin
    seg_d  = SEG_BLANK;
    dp_d   = 1'b1;
    an_d   = 4'hF;
    beep_d = 1'b0;
    if (valid_q && !(zero_q && !phase_q)) begin
      an_d   = ~(4'b0001 << dig_q);
      beep_d = zero_q;
      if (dig_q != 2'd3) begin
        seg_d = cur_seg_c;
      end
      if (dig_q == 2'd2) begin
        dp_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_q      <= '0;
      rem_q       <= '0;
      min_q       <= '0;
      tens_q      <= '0;
      digits_q    <= '0;
      zero_q      <= 1'b0;
      valid_q     <= 1'b0;
      scan_cnt_q  <= '0;
      dig_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      an_q        <= 4'hF;
      beep_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      rem_q       <= rem_d;
      min_q       <= min_d;
      tens_q      <= tens_d;
      digits_q    <= digits_d;
      zero_q      <= zero_d;
      valid_q     <= valid_d;
      scan_cnt_q  <= scan_cnt_d;
      dig_q       <= dig_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      beep_q      <= beep_d;
    end
  end

  assign seg  = seg_q;
  assign dp   = dp_q;
  assign an   = an_q;
  assign beep = beep_q;

endmodule
